pong_referee: RTL and testbench

Game-control counterpart to the bouncing one-hot ball counter on the 16-LED Pong board. The block reads the ball position and the two player buttons, decides hits and misses, and keeps score. It drives the counter's pause/turn inputs, holding the ball at the serving end between points. Runs on the same game-tick clock as the ball counter.

---
 rtl/pong_pkg.sv | 13 +
 rtl/pong_paddle.sv | 77 +++++++
 rtl/pong_referee.sv | 178 +++++++++++++++++
 tb/tb_pong_referee.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong referee: FSM states, side encoding, board geometry.
package pong_pkg;

  typedef enum logic [1:0] {StServe, StPlay, StPoint, StOver} state_e;

  localparam bit LEFT  = 1'b0;
  localparam bit RIGHT = 1'b1;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefHitWin   = 3;
  localparam int unsigned DefWinScore = 7;

endpackage

// File: rtl/pong_paddle.sv
// One player's end of the board: button edge detect, arm/lockout flags, and hit/miss decision.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned HIT_WIN = DefHitWin,
  parameter bit          SIDE    = LEFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             mv_left_i,
  input  logic [WIDTH-1:0] ball_i,
  output logic             press_o,
  output logic             hit_o,
  output logic             miss_o
);

  localparam int unsigned WinLo  = (SIDE == LEFT) ? 0 : WIDTH - HIT_WIN;
  localparam int unsigned EndBit = (SIDE == LEFT) ? 0 : WIDTH - 1;

  logic btn_q;
  logic arm_q, arm_d;
  logic lock_q, lock_d;
  logic approach, in_win, at_end;

  assign press_o  = btn_i & ~btn_q;
  assign approach = (SIDE == LEFT) ? mv_left_i : ~mv_left_i;
  assign in_win   = |ball_i[WinLo +: HIT_WIN];
  assign at_end   = ball_i[EndBit];

  always_comb begin
    arm_d  = arm_q;
    lock_d = lock_q;
    hit_o  = 1'b0;
    miss_o = 1'b0;
    if (clr_i) begin
      arm_d  = 1'b0;
      lock_d = 1'b0;
    end else if (en_i) begin
      if (!approach) begin
        // Ball heading away: presses are ignored and any stale flags drop.
        arm_d  = 1'b0;
        lock_d = 1'b0;
      end else if (at_end) begin
        if (arm_q || (press_o && !lock_q)) begin
          hit_o = 1'b1;
        end else begin
          miss_o = 1'b1;
        end
        arm_d  = 1'b0;
        lock_d = 1'b0;
      end else if (press_o) begin
        if (!in_win) begin
          lock_d = 1'b1;
        end else if (!lock_q) begin
          arm_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q  <= 1'b0;
      arm_q  <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      btn_q  <= btn_i;
      arm_q  <= arm_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/pong_referee.sv
// Pong referee: serve/play/point/over FSM, ball direction tracking and score keeping.
module pong_referee
  import pong_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned HIT_WIN   = DefHitWin,
  parameter int unsigned WIN_SCORE = DefWinScore,
  parameter int unsigned SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   ball,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               new_game,
  output logic               pause,
  output logic               turn,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               point,
  output logic               hit,
  output logic               game_over,
  output logic               winner
);

  localparam logic [WIDTH-1:0]   LeftEnd  = WIDTH'(1);
  localparam logic [WIDTH-1:0]   RightEnd = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic               turn_q, turn_d;
  logic               winner_q, winner_d;
  logic               loser_q, loser_d;
  logic               dir_q, dir_d;
  logic               point_q, point_d;
  logic               hit_q, hit_d;
  logic [WIDTH-1:0]   prev_ball_q, prev_ball_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [SCORE_W-1:0] inc_l, inc_r;

  logic ball_ok, mv_left, en, clr;
  logic press_l, press_r, hit_l, hit_r, miss_l, miss_r;

  assign ball_ok = (ball != '0) && ((ball & (ball - WIDTH'(1))) == '0);
  assign mv_left = (ball != prev_ball_q) ? (ball < prev_ball_q) : dir_q;
  assign en      = (state_q == StPlay) && ball_ok;
  assign inc_l   = (score_l_q >= WinScore) ? score_l_q : score_l_q + 1'b1;
  assign inc_r   = (score_r_q >= WinScore) ? score_r_q : score_r_q + 1'b1;

  pong_paddle #(.WIDTH(WIDTH), .HIT_WIN(HIT_WIN), .SIDE(LEFT)) u_paddle_l (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_l),
    .en_i     (en),
    .clr_i    (clr),
    .mv_left_i(mv_left),
    .ball_i   (ball),
    .press_o  (press_l),
    .hit_o    (hit_l),
    .miss_o   (miss_l)
  );

  pong_paddle #(.WIDTH(WIDTH), .HIT_WIN(HIT_WIN), .SIDE(RIGHT)) u_paddle_r (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_r),
    .en_i     (en),
    .clr_i    (clr),
    .mv_left_i(mv_left),
    .ball_i   (ball),
    .press_o  (press_r),
    .hit_o    (hit_r),
    .miss_o   (miss_r)
  );

  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    loser_d     = loser_q;
    dir_d       = dir_q;
    prev_ball_d = prev_ball_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    point_d     = 1'b0;
    hit_d       = 1'b0;
    clr         = 1'b0;
    unique case (state_q)
      StServe: begin
        if (turn_q ? press_r : press_l) begin
          state_d     = StPlay;
          prev_ball_d = turn_q ? RightEnd : LeftEnd;
          dir_d       = turn_q;
        end
      end
      StPlay: begin
        // Corrupt ball vectors freeze the rally rather than guess a position.
        if (ball_ok) begin
          prev_ball_d = ball;
          dir_d       = mv_left;
          hit_d       = hit_l | hit_r;
          if (miss_l) begin
            loser_d = LEFT;
            state_d = StPoint;
          end else if (miss_r) begin
            loser_d = RIGHT;
            state_d = StPoint;
          end
        end
      end
      StPoint: begin
        clr     = 1'b1;
        point_d = 1'b1;
        turn_d  = loser_q;
        state_d = StServe;
        if (loser_q == LEFT) begin
          score_r_d = inc_r;
          if (inc_r == WinScore) begin
            state_d  = StOver;
            winner_d = RIGHT;
          end
        end else begin
          score_l_d = inc_l;
          if (inc_l == WinScore) begin
            state_d  = StOver;
            winner_d = LEFT;
          end
        end
      end
      StOver: begin
        if (new_game) begin
          clr       = 1'b1;
          score_l_d = '0;
          score_r_d = '0;
          turn_d    = LEFT;
          state_d   = StServe;
        end
      end
      default: state_d = StServe;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StServe;
      turn_q      <= LEFT;
      winner_q    <= LEFT;
      loser_q     <= LEFT;
      dir_q       <= 1'b0;
      prev_ball_q <= LeftEnd;
      score_l_q   <= '0;
      score_r_q   <= '0;
      point_q     <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      loser_q     <= loser_d;
      dir_q       <= dir_d;
      prev_ball_q <= prev_ball_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      point_q     <= point_d;
      hit_q       <= hit_d;
    end
  end

  assign pause     = (state_q != StPlay);
  assign game_over = (state_q == StOver);
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign point     = point_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_pong_referee.sv
// Directed bench for pong_referee: stimulus queues expected hit/point events, a monitor checks them.
module tb_pong_referee;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ball;
  logic        btn_l, btn_r, new_game;
  logic        pause, turn, point, hit, game_over, winner;
  logic [3:0]  score_l, score_r;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       hit;
    logic       point;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       turn;
    logic       pause;
    logic       over;
  } ev_t;

  ev_t exp_q[$];

  pong_referee #(
    .WIDTH    (16),
    .HIT_WIN  (3),
    .WIN_SCORE(7),
    .SCORE_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ball     (ball),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .new_game (new_game),
    .pause    (pause),
    .turn     (turn),
    .score_l  (score_l),
    .score_r  (score_r),
    .point    (point),
    .hit      (hit),
    .game_over(game_over),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  // Monitor: every hit/point pulse must match the next queued expectation.
  always @(negedge clk) begin
    ev_t got;
    ev_t e;
    if (hit || point) begin
      got = {hit, point, score_l, score_r, turn, pause, game_over};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL event_unexpected: got hit=%0b point=%0b sl=%0d sr=%0d turn=%0b pause=%0b over=%0b, expected no event",
                 got.hit, got.point, got.sl, got.sr, got.turn, got.pause, got.over);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL event: got hit=%0b point=%0b sl=%0d sr=%0d turn=%0b pause=%0b over=%0b, expected hit=%0b point=%0b sl=%0d sr=%0d turn=%0b pause=%0b over=%0b",
                   got.hit, got.point, got.sl, got.sr, got.turn, got.pause, got.over,
                   e.hit, e.point, e.sl, e.sr, e.turn, e.pause, e.over);
        end
      end
    end
  end

  task automatic push(input logic h, input logic p, input int sl, input int sr,
                      input logic t, input logic pa, input logic ov);
    ev_t e;
    e.hit   = h;
    e.point = p;
    e.sl    = 4'(sl);
    e.sr    = 4'(sr);
    e.turn  = t;
    e.pause = pa;
    e.over  = ov;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ball(input int b);
    ball    = '0;
    ball[b] = 1'b1;
  endtask

  // One ball position per cycle from bit 'from' to bit 'to'; press a button at pl / pr (-1 = never).
  task automatic walk(input int from, input int to, input int pl, input int pr);
    int d;
    int n;
    int b;
    d = (to >= from) ? 1 : -1;
    n = (to >= from) ? to - from : from - to;
    for (int i = 0; i <= n; i++) begin
      b = from + i * d;
      set_ball(b);
      btn_l = (b == pl);
      btn_r = (b == pr);
      tick();
    end
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask

  task automatic serve(input logic side);
    set_ball(side ? 15 : 0);
    btn_l = ~side;
    btn_r = side;
    tick();
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    ball     = 16'h0001;
    btn_l    = 1'b0;
    btn_r    = 1'b0;
    new_game = 1'b0;
    #1 rst = 1'b0;
    tick();
    tick();
    chk("rst_pause", pause, 1);
    chk("rst_turn", turn, 0);
    chk("rst_score_l", score_l, 0);
    chk("rst_score_r", score_r, 0);
    chk("rst_point_hit", {point, hit}, 0);
    chk("rst_over_winner", {game_over, winner}, 0);
    rst = 1'b1;
    tick();

    // Rally: right returns from armed press, left arms at bit 2 and returns, then left misses.
    serve(1'b0);
    chk("play_pause", pause, 0);
    push(1, 0, 0, 0, 0, 0, 0);
    walk(0, 15, -1, 14);
    push(1, 0, 0, 0, 0, 0, 0);
    walk(14, 0, 2, -1);
    push(1, 0, 0, 0, 0, 0, 0);
    walk(1, 15, -1, 14);
    push(0, 1, 0, 1, 0, 1, 0);
    walk(14, 0, -1, -1);
    tick();
    chk("serve_pause", pause, 1);

    // Left missed, so left serves: a right press must not start play.
    btn_r = 1'b1;
    tick();
    btn_r = 1'b0;
    tick();
    chk("wrong_serve_ignored", pause, 1);
    serve(1'b0);
    chk("serve_started", pause, 0);

    // Same-cycle return at bit 15, then early left press locks out the later one.
    push(1, 0, 0, 1, 0, 0, 0);
    walk(0, 15, -1, 15);
    push(0, 1, 0, 2, 0, 1, 0);
    walk(14, 0, 5, 1);
    tick();

    // Right misses with no press.
    serve(1'b0);
    push(0, 1, 1, 2, 1, 1, 0);
    walk(0, 15, -1, -1);
    tick();
    chk("right_serve_turn", turn, 1);

    // Right serves; bad ball vectors freeze the rally, then async reset mid-rally.
    serve(1'b1);
    walk(15, 11, -1, -1);
    ball = 16'h0000;
    tick();
    tick();
    ball = 16'h0003;
    tick();
    chk("glitch_pause", pause, 0);
    chk("glitch_scores", {score_l, score_r}, 8'h12);
    walk(10, 8, -1, -1);
    chk("midrally_pause", pause, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_pause", pause, 1);
    chk("async_turn", turn, 0);
    chk("async_scores", {score_l, score_r}, 0);
    set_ball(0);
    tick();
    rst = 1'b1;
    tick();

    // Left wins 7-0: right misses every time.
    serve(1'b0);
    push(0, 1, 1, 0, 1, 1, 0);
    walk(0, 15, -1, -1);
    tick();
    for (int k = 2; k <= 7; k++) begin
      serve(1'b1);
      push(1, 0, k - 1, 0, 1, 0, 0);
      walk(15, 0, 1, -1);
      push(0, 1, k, 0, 1, 1, (k == 7));
      walk(1, 15, -1, -1);
      tick();
    end
    chk("over_flag", game_over, 1);
    chk("over_winner", winner, 0);
    chk("over_score_l", score_l, 7);
    chk("over_pause", pause, 1);
    btn_l = 1'b1;
    btn_r = 1'b1;
    tick();
    btn_l = 1'b0;
    btn_r = 1'b0;
    tick();
    chk("over_press_ignored", {game_over, score_l}, 5'h17);
    new_game = 1'b1;
    set_ball(0);
    tick();
    new_game = 1'b0;
    chk("new_game_scores", {score_l, score_r}, 0);
    chk("new_game_turn", turn, 0);
    chk("new_game_over", game_over, 0);
    chk("new_game_pause", pause, 1);
    serve(1'b0);
    chk("new_game_serve", pause, 0);
    tick();
    tick();
    chk("events_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
